// File: rtl/seg7_pkg.sv
// Shared BCD digit width, 7-segment glyphs {g,f,e,d,c,b,a} (active-high) and the BCD decoder.
package seg7_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Non-BCD codes render blank; they cannot occur in the digit state.
    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [BCD_W-1:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit: saturating synchronous load, increment/decrement with carry/borrow to the next digit.
module bcd_digit_cell
    import seg7_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    output logic [BCD_W-1:0] digit,
    output logic             carry_c,
    output logic             borrow_c
);

    localparam logic [BCD_W-1:0] NINE = BCD_W'(9);

    // Ripple to the next digit when this one rolls over.
    assign carry_c  = inc & (digit == NINE);
    assign borrow_c = dec & (digit == '0);

    // Digit state; load wins over any step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= '0;
        end else if (load) begin
            digit <= (load_val > NINE) ? NINE : load_val;
        end else if (inc) begin
            digit <= (digit == NINE) ? '0 : digit + BCD_W'(1);
        end else if (dec) begin
            digit <= (digit == '0) ? NINE : digit - BCD_W'(1);
        end
    end

endmodule

// File: rtl/bcd_counter_7seg_mux.sv
// N-digit BCD up/down counter with rate prescaler, driving a multiplexed 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).
module bcd_counter_7seg_mux
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE_W = 24,
    parameter int unsigned SCAN_DIV_W = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          up_dn,
    input  logic                          load,
    input  logic [BCD_W*NUM_DIGITS-1:0]   load_val,
    input  logic [PRESCALE_W-1:0]         prescale,
    output logic [BCD_W*NUM_DIGITS-1:0]   count_out,
    output logic                          wrap,
    output logic [SEG_W-1:0]              seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         digit_sel
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRESCALE_W-1:0]               pre_cnt;
    logic                                tick_c;
    logic                                heartbeat;
    logic [SCAN_DIV_W-1:0]               scan_div;
    logic [IDX_W-1:0]                    idx;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]    digits;
    logic [NUM_DIGITS:0]                 carry;
    logic [NUM_DIGITS:0]                 borrow;
    logic [BCD_W-1:0]                    cur_digit_c;
    logic                                blank_c;

    // A load owns the cycle, so it suppresses the tick and leaves the phase cleared.
    assign tick_c    = en & ~load & (pre_cnt >= prescale);
    assign carry[0]  = tick_c & up_dn;
    assign borrow[0] = tick_c & ~up_dn;

    // Rate prescaler: counts enabled cycles, clears on tick or load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (load) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= tick_c ? '0 : pre_cnt + PRESCALE_W'(1);
        end
    end

    // Digit chain, digit 0 receives the tick.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .load     (load),
            .load_val (load_val[i*BCD_W +: BCD_W]),
            .inc      (carry[i]),
            .dec      (borrow[i]),
            .digit    (digits[i]),
            .carry_c  (carry[i+1]),
            .borrow_c (borrow[i+1])
        );
    end

    assign count_out = digits;

    // Full-range wrap pulse and tick heartbeat for the decimal point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap      <= 1'b0;
            heartbeat <= 1'b0;
        end else begin
            wrap      <= carry[NUM_DIGITS] | borrow[NUM_DIGITS];
            heartbeat <= heartbeat ^ tick_c;
        end
    end

    // Free-running scan divider and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_div <= '0;
            idx      <= '0;
        end else begin
            scan_div <= scan_div + SCAN_DIV_W'(1);
            if (&scan_div) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    assign cur_digit_c = digits[idx];

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] zero_above_c;

    // zero_above_c[i]: digit i and every higher digit are zero.
    always_comb begin
        zero_above_c = '0;
        zero_above_c[NUM_DIGITS-1] = (digits[NUM_DIGITS-1] == '0);
        for (int i = int'(NUM_DIGITS) - 2; i >= 0; i--) begin
            zero_above_c[i] = zero_above_c[i+1] & (digits[i] == '0);
        end
    end

    assign blank_c = (idx != '0) & zero_above_c[idx];
`else
    assign blank_c = 1'b0;
`endif

    // Segment, dp and select registered together so they never disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg       <= '0;
            dp        <= 1'b0;
            digit_sel <= '0;
        end else begin
            seg       <= blank_c ? SEG_BLANK : bcd_to_seg(cur_digit_c);
            dp        <= (idx == '0) ? heartbeat : 1'b0;
            digit_sel <= NUM_DIGITS'(1) << idx;
        end
    end

endmodule

// File: tb/tb_bcd_counter_7seg_mux.sv
// Randomized bench against an integer-valued reference model of the counter and display scan.
module tb_bcd_counter_7seg_mux;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = 8;
    localparam int unsigned SW = 2;
    localparam int unsigned CW = 4 * N;
    localparam int          MAXV = 10 ** N;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          up_dn;
    logic          load;
    logic [CW-1:0] load_val;
    logic [PW-1:0] prescale;
    logic [CW-1:0] count_out;
    logic          wrap;
    logic [6:0]    seg;
    logic          dp;
    logic [N-1:0]  digit_sel;

    int total = 0;
    int bad   = 0;

    // Reference model state: count as a plain integer, prescale phase, heartbeat, edges since reset.
    int m_val;
    int m_pre;
    bit m_hb;
    int m_k;

    logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    bcd_counter_7seg_mux #(
        .NUM_DIGITS (N),
        .PRESCALE_W (PW),
        .SCAN_DIV_W (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .prescale  (prescale),
        .count_out (count_out),
        .wrap      (wrap),
        .seg       (seg),
        .dp        (dp),
        .digit_sel (digit_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] to_bcd(input int v);
        logic [CW-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(N); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_load(input logic [CW-1:0] lv);
        int r;
        int d;
        r = 0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_val = 0;
        m_pre = 0;
        m_hb  = 1'b0;
        m_k   = 0;
    endtask

    // One clock edge with the currently driven inputs, then check every output against the model.
    task automatic step();
        int         idx;
        int         d;
        bit         blank;
        bit         tick;
        bit         exp_wrap;
        int         nval;
        logic [6:0] exp_seg;
        logic [N-1:0] exp_sel;
        logic       exp_dp;

        idx   = (m_k / (1 << SW)) % int'(N);
        d     = (m_val / (10 ** idx)) % 10;
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx > 0) && ((m_val / (10 ** idx)) == 0);
`endif
        exp_seg = blank ? 7'h00 : segtab[d];
        exp_sel = N'(1) << idx;
        exp_dp  = (idx == 0) ? m_hb : 1'b0;

        tick     = en && !load && (m_pre >= int'(prescale));
        exp_wrap = 1'b0;
        nval     = m_val;
        if (load) begin
            nval = from_load(load_val);
        end else if (tick) begin
            if (up_dn) begin
                exp_wrap = (m_val == MAXV - 1);
                nval = (m_val + 1) % MAXV;
            end else begin
                exp_wrap = (m_val == 0);
                nval = (m_val + MAXV - 1) % MAXV;
            end
        end

        @(posedge clk);
        #1;
        if (load)     m_pre = 0;
        else if (en)  m_pre = tick ? 0 : m_pre + 1;
        m_val = nval;
        m_hb  = m_hb ^ tick;
        m_k++;

        check("count_out", 32'(count_out), 32'(to_bcd(m_val)));
        check("wrap", 32'(wrap), 32'(exp_wrap));
        check("seg", 32'(seg), 32'(exp_seg));
        check("dp", 32'(dp), 32'(exp_dp));
        check("digit_sel", 32'(digit_sel), 32'(exp_sel));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [CW-1:0] v);
        load     = 1'b1;
        load_val = v;
        step();
        load     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"}, 32'(seg), 32'h0);
        check({tag, "_dp"}, 32'(dp), 32'h0);
        check({tag, "_sel"}, 32'(digit_sel), 32'h0);
        check({tag, "_cnt"}, 32'(count_out), 32'h0);
        check({tag, "_wrap"}, 32'(wrap), 32'h0);
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        up_dn    = 1'b1;
        load     = 1'b0;
        load_val = '0;
        prescale = '0;
        model_reset();

        // Reset held, then first edge after release.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        step();
        check("release_sel", 32'(digit_sel), 32'h1);
        check("release_seg", 32'(seg), 32'h3F);

        // Count up every cycle.
        do_load('0);
        en = 1'b1;
        up_dn = 1'b1;
        prescale = '0;
        steps(10);
        check("up10", 32'(count_out), 32'h0010);

        // Up wrap from all nines.
        do_load(16'h9999);
        step();
        check("upwrap_cnt", 32'(count_out), 32'h0000);
        check("upwrap_pulse", 32'(wrap), 32'h1);
        step();
        check("upwrap_gone", 32'(wrap), 32'h0);

        // Down wrap from zero, then borrow across digits without wrap.
        up_dn = 1'b0;
        do_load('0);
        step();
        check("dnwrap_cnt", 32'(count_out), 32'h9999);
        check("dnwrap_pulse", 32'(wrap), 32'h1);
        do_load(16'h0100);
        step();
        check("borrow_cnt", 32'(count_out), 32'h0099);
        check("borrow_nowrap", 32'(wrap), 32'h0);

        // Saturating load, and load beating a tick.
        en = 1'b0;
        do_load(16'h12F4);
        check("load_sat", 32'(count_out), 32'h1294);
        en = 1'b1;
        up_dn = 1'b1;
        do_load(16'h0500);
        check("load_vs_tick", 32'(count_out), 32'h0500);

        // Prescale of 3 with a pause that preserves phase.
        prescale = 8'd3;
        do_load('0);
        steps(8);
        check("pre3", 32'(count_out), 32'h0002);
        steps(2);
        en = 1'b0;
        steps(5);
        check("pre3_frozen", 32'(count_out), 32'h0002);
        en = 1'b1;
        steps(2);
        check("pre3_resume", 32'(count_out), 32'h0003);
        steps(3);

        // Scan sequences over fixed counts.
        en = 1'b0;
        do_load(16'h1234);
        steps(20);
        do_load(16'h0042);
        steps(20);
        do_load(16'h0000);
        steps(20);

        // Randomized operation.
        for (int i = 0; i < 4000; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = $urandom_range(0, 1);
            if ($urandom_range(0, 63) == 0) prescale = PW'($urandom_range(0, 3));
            load     = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       load_val = 16'h9999;
                1:       load_val = 16'h0000;
                2:       load_val = 16'h0998;
                default: load_val = CW'($urandom);
            endcase
            step();
        end
        load = 1'b0;

        // Asynchronous reset mid-run.
        en = 1'b1;
        do_load(16'h0567);
        steps(3);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        #2;
        rst = 1'b0;
        model_reset();
        steps(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
